// File: rtl/ls86_serial_descrambler.sv
// Self-synchronizing x^7+x^6+1 serial descrambler with flush, idle lock and loss-of-lock tracking.
// Optional LS86_DESCR_LOLCNT_EN enables the saturating loss-of-lock event counter.
module ls86_serial_descrambler #(
  parameter int WIDTH        = 7,
  parameter int TAP_A        = 5,
  parameter int TAP_B        = 6,
  parameter int LOCK_COUNT   = 32,
  parameter int UNLOCK_COUNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       out_valid,
  output logic       out_bit,
  output logic       locked,
  output logic [7:0] lol_count
);

  localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ?
                           LOCK_COUNT : UNLOCK_COUNT;
  localparam int CW = $clog2(RUN_MAX + 1);
  localparam int FW = $clog2(WIDTH + 1);

  localparam logic [FW-1:0] FLUSH_LAST  = FW'(WIDTH - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_COUNT - 1);
  localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_COUNT - 1);

  typedef enum logic [1:0] {
    FLUSH,
    SEARCH,
    LOCKED
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sr;
  logic [FW-1:0]   fcnt;
  logic [CW-1:0]   zrun;
  logic [CW-1:0]   orun;
  logic            d;

  // Taps see the raw received stream, so the descrambler resyncs by itself.
  assign d = in_bit ^ sr[TAP_A] ^ sr[TAP_B];

`ifdef LS86_DESCR_LOLCNT_EN
  logic [7:0] lol_q;
  assign lol_count = lol_q;
`else
  assign lol_count = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      sr        <= '0;
      fcnt      <= '0;
      zrun      <= '0;
      orun      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      locked    <= 1'b0;
`ifdef LS86_DESCR_LOLCNT_EN
      lol_q     <= 8'h00;
`endif
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        sr <= {sr[WIDTH-2:0], in_bit};
        unique case (state)
          FLUSH: begin
            if (fcnt == FLUSH_LAST) begin
              state <= SEARCH;
              fcnt  <= '0;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
          SEARCH: begin
            out_valid <= 1'b1;
            out_bit   <= d;
            if (d) begin
              zrun <= '0;
            end else if (zrun == LOCK_LAST) begin
              state  <= LOCKED;
              locked <= 1'b1;
              zrun   <= '0;
            end else begin
              zrun <= zrun + 1'b1;
            end
          end
          LOCKED: begin
            out_valid <= 1'b1;
            out_bit   <= d;
            if (!d) begin
              orun <= '0;
            end else if (orun == UNLOCK_LAST) begin
              state  <= SEARCH;
              locked <= 1'b0;
              orun   <= '0;
              zrun   <= '0;
`ifdef LS86_DESCR_LOLCNT_EN
              if (lol_q != 8'hFF) lol_q <= lol_q + 8'h01;
`endif
            end else begin
              orun <= orun + 1'b1;
            end
          end
          default: state <= FLUSH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ls86_serial_descrambler.sv
// Randomized and directed bench for ls86_serial_descrambler.
// Reference: bit-history queue model plus a bench-side x^7+x^6+1 scrambler.
module tb_ls86_serial_descrambler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_valid;
  logic       out_bit;
  logic       locked;
  logic [7:0] lol_count;

  int checks = 0;
  int errors = 0;

`ifdef LS86_DESCR_LOLCNT_EN
  localparam int LOL_EN = 1;
`else
  localparam int LOL_EN = 0;
`endif

  ls86_serial_descrambler dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .locked   (locked),
    .lol_count(lol_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit   hist[$];
  int   nflush;
  int   zr;
  int   orr;
  bit   exp_ov;
  bit   exp_ob;
  bit   exp_lk;
  int   exp_lol;
  logic [6:0] sc;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < 7; i++) hist.push_back(1'b0);
    nflush  = 0;
    zr      = 0;
    orr     = 0;
    exp_ov  = 1'b0;
    exp_ob  = 1'b0;
    exp_lk  = 1'b0;
    exp_lol = 0;
  endtask

  task automatic model(input bit r, input bit v, input bit b);
    bit d;
    if (r) begin
      model_reset();
    end else if (v) begin
      // bits received 6 and 7 valid cycles ago
      d = b ^ hist[hist.size() - 6] ^ hist[hist.size() - 7];
      hist.push_back(b);
      void'(hist.pop_front());
      if (nflush < 7) begin
        nflush++;
        exp_ov = 1'b0;
      end else begin
        exp_ov = 1'b1;
        exp_ob = d;
        if (!exp_lk) begin
          zr = d ? 0 : zr + 1;
          if (zr == 32) begin
            exp_lk = 1'b1;
            zr     = 0;
            orr    = 0;
          end
        end else begin
          orr = d ? orr + 1 : 0;
          if (orr == 8) begin
            exp_lk = 1'b0;
            orr    = 0;
            zr     = 0;
            if (LOL_EN == 1 && exp_lol < 255) exp_lol++;
          end
        end
      end
    end else begin
      exp_ov = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit b);
    rst      = r;
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    model(r, v, b);
    #1;
    chk("out_valid", {7'd0, out_valid}, {7'd0, exp_ov});
    chk("out_bit",   {7'd0, out_bit},   {7'd0, exp_ob});
    chk("locked",    {7'd0, locked},    {7'd0, exp_lk});
    chk("lol_count", lol_count,         exp_lol[7:0]);
  endtask

  // Scramble one data bit and send it as a valid input.
  task automatic send(input bit data);
    bit s;
    s  = data ^ sc[5] ^ sc[6];
    sc = {sc[5:0], s};
    step(1'b0, 1'b1, s);
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic run_lock(input bit gapped);
    step(1'b1, 1'b1, 1'b1);
    sc = 7'h7F;
    for (int i = 1; i <= 39; i++) begin
      if (gapped) gap();
      send(1'b0);
      if (i == 7) chk("flush_quiet", {7'd0, out_valid}, 8'd0);
      if (i > 7) chk("zero_out", {7'd0, out_bit}, 8'd0);
      if (i == 38) chk("not_yet_lock", {7'd0, locked}, 8'd0);
      if (i == 39) chk("lock_32", {7'd0, locked}, 8'd1);
    end
  endtask

  initial begin
    model_reset();
    sc = 7'h7F;

    // Reset held with in_valid high
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_ov",  {7'd0, out_valid}, 8'd0);
    chk("rst_ob",  {7'd0, out_bit},   8'd0);
    chk("rst_lk",  {7'd0, locked},    8'd0);
    chk("rst_lol", lol_count,         8'd0);

    // Flush: seven ones produce nothing, the eighth yields 1^1^1
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("flush_ov", {7'd0, out_valid}, 8'd0);
    end
    step(1'b0, 1'b1, 1'b1);
    chk("flush8_ov", {7'd0, out_valid}, 8'd1);
    chk("flush8_ob", {7'd0, out_bit},   8'd1);

    // Continuous and gapped lock
    run_lock(1'b0);
    run_lock(1'b1);
    gap();
    chk("gap_ov", {7'd0, out_valid}, 8'd0);

    // Loss of lock on scrambled ones, then relock
    for (int i = 1; i <= 8; i++) begin
      send(1'b1);
      chk("ones_out", {7'd0, out_bit}, 8'd1);
      if (i == 7) chk("still_lock", {7'd0, locked}, 8'd1);
    end
    chk("lol_unlock", {7'd0, locked}, 8'd0);
    chk("lol_cnt1", lol_count, 8'(LOL_EN));
    for (int i = 0; i < 32; i++) send(1'b0);
    chk("relock", {7'd0, locked}, 8'd1);

    // Mid-operation reset while locked
    step(1'b1, 1'b1, 1'b0);
    chk("mid_lk",  {7'd0, locked},    8'd0);
    chk("mid_ov",  {7'd0, out_valid}, 8'd0);
    chk("mid_lol", lol_count,         8'd0);
    for (int i = 0; i < 7; i++) begin
      send(1'b0);
      chk("reflush_ov", {7'd0, out_valid}, 8'd0);
    end
    send(1'b0);
    chk("reflush_out", {7'd0, out_valid}, 8'd1);

    // Randomized segments with varying ones density
    for (int seg = 0; seg < 16; seg++) begin
      int pct;
      case (seg % 4)
        0: pct = 0;
        1: pct = 100;
        2: pct = 3;
        default: pct = 50;
      endcase
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 499) == 0) begin
          step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 9) < 8) begin
          send(1'($urandom_range(0, 99) < pct));
        end else begin
          gap();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
